// File: rtl/alu_bus_arbiter.sv
// Two-master arbiter in front of a single shared ALU: IDLE -> EXEC (EXEC_CYC cycles) -> DONE.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] ALU_result
);
  always_comb begin
    ALU_result = 32'h0000_0000;
    case (op)
      4'd1: ALU_result = ~a;
      4'd2: ALU_result = a & b;
      4'd3: ALU_result = a | b;
      4'd4: ALU_result = a ^ b;
      4'd5: ALU_result = ~(a ^ b);
      4'd6: ALU_result = a + b;
      4'd7: ALU_result = a - b;
      default: ALU_result = 32'h0000_0000;
    endcase
  end
endmodule

module alu_bus_arbiter #(
  parameter int EXEC_CYC = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [3:0]  m0_op,
  input  logic [3:0]  m1_op,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_b,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_b,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] result,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        win_q, win_d;
  logic        m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic        m0_done_q, m0_done_d, m1_done_q, m1_done_d;
  logic        pick_m1;
  logic [3:0]  win_op;
  logic [31:0] alu_result;

`ifdef ALU_ARB_RR_EN
  // ptr_q high means m0 was granted last, so m1 takes the next tie
  logic ptr_q, ptr_d;
  assign pick_m1 = m1_req & (~m0_req | ptr_q);
`else
  assign pick_m1 = m1_req & ~m0_req;
`endif

  assign win_op = pick_m1 ? m1_op : m0_op;

  alu u_alu (
    .a          (a_q),
    .b          (b_q),
    .op         (op_q),
    .ALU_result (alu_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    win_d     = win_q;
    m0_gnt_d  = 1'b0;
    m1_gnt_d  = 1'b0;
    m0_done_d = 1'b0;
    m1_done_d = 1'b0;
`ifdef ALU_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          state_d  = EXEC;
          cnt_d    = 4'd0;
          win_d    = pick_m1;
          // opcodes 8..15 are undefined and collapse to NOP
          op_d     = win_op[3] ? 4'd0 : win_op;
          a_d      = pick_m1 ? m1_a : m0_a;
          b_d      = pick_m1 ? m1_b : m0_b;
          m0_gnt_d = ~pick_m1;
          m1_gnt_d = pick_m1;
`ifdef ALU_ARB_RR_EN
          ptr_d    = ~pick_m1;
`endif
        end
      end
      EXEC: begin
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          cnt_d     = 4'd0;
          result_d  = alu_result;
          m0_done_d = ~win_q;
          m1_done_d = win_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 4'd0;
      a_q       <= 32'h0000_0000;
      b_q       <= 32'h0000_0000;
      result_q  <= 32'h0000_0000;
      win_q     <= 1'b0;
      m0_gnt_q  <= 1'b0;
      m1_gnt_q  <= 1'b0;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      win_q     <= win_d;
      m0_gnt_q  <= m0_gnt_d;
      m1_gnt_q  <= m1_gnt_d;
      m0_done_q <= m0_done_d;
      m1_done_q <= m1_done_d;
`ifdef ALU_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign m0_gnt  = m0_gnt_q;
  assign m1_gnt  = m1_gnt_q;
  assign m0_done = m0_done_q;
  assign m1_done = m1_done_q;
  assign result  = result_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_alu_bus_arbiter.sv
// Self-checking bench for alu_bus_arbiter: two instances (EXEC_CYC=1 and 3) share stimulus,
// a transaction-level model predicts grants, done pulses and results.

module tb_alu_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [3:0]  m0_op = 4'd0, m1_op = 4'd0;
  logic [31:0] m0_a = '0, m0_b = '0, m1_a = '0, m1_b = '0;

  logic        d1_m0_gnt, d1_m1_gnt, d1_m0_done, d1_m1_done, d1_busy;
  logic        d3_m0_gnt, d3_m1_gnt, d3_m0_done, d3_m1_done, d3_busy;
  logic [31:0] d1_result, d3_result;

  logic        sel3 = 1'b0;
  logic [4:0]  flags;
  logic [31:0] res;

  int n_checks = 0;
  int n_fail   = 0;
  int last_w   = 1;
  int txn_no   = 0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  alu_bus_arbiter #(.EXEC_CYC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .m0_req(m0_req), .m1_req(m1_req),
    .m0_op(m0_op), .m1_op(m1_op), .m0_a(m0_a), .m0_b(m0_b), .m1_a(m1_a), .m1_b(m1_b),
    .m0_gnt(d1_m0_gnt), .m1_gnt(d1_m1_gnt), .m0_done(d1_m0_done), .m1_done(d1_m1_done),
    .result(d1_result), .busy(d1_busy)
  );

  alu_bus_arbiter #(.EXEC_CYC(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .m0_req(m0_req), .m1_req(m1_req),
    .m0_op(m0_op), .m1_op(m1_op), .m0_a(m0_a), .m0_b(m0_b), .m1_a(m1_a), .m1_b(m1_b),
    .m0_gnt(d3_m0_gnt), .m1_gnt(d3_m1_gnt), .m0_done(d3_m0_done), .m1_done(d3_m1_done),
    .result(d3_result), .busy(d3_busy)
  );

  assign flags = sel3 ? {d3_m0_gnt, d3_m1_gnt, d3_m0_done, d3_m1_done, d3_busy}
                      : {d1_m0_gnt, d1_m1_gnt, d1_m0_done, d1_m1_done, d1_busy};
  assign res   = sel3 ? d3_result : d1_result;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1: return ~a;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a ^ b);
      4'd6: return a + b;
      4'd7: return a - b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef ALU_ARB_RR_EN
    return (last_w == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    last_w = 1;
    exp_result = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One complete operation starting from an IDLE cycle with requests already driven.
  task automatic run_op(input bit keep);
    int w, ecyc;
    logic [3:0] op;
    logic [31:0] a, b, exp;
    logic [4:0] fe;
    ecyc = sel3 ? 3 : 1;
    w  = pick(m0_req, m1_req);
    op = w ? m1_op : m0_op;
    a  = w ? m1_a : m0_a;
    b  = w ? m1_b : m0_b;
    exp = alu_ref(op, a, b);
    @(posedge clk); #1;
    fe = {w == 0, w == 1, 3'b001};
    n_checks++;
    if (flags !== fe) begin
      $display("FAIL grant: flags got %b expected %b", flags, fe); n_fail++;
    end
    last_w = w;
    if (!keep) begin
      if (w == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
    for (int i = 1; i < ecyc; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({flags, res} !== {5'b00001, exp_result}) begin
        $display("FAIL exec: flags/result got %b/%h expected %b/%h", flags, res, 5'b00001, exp_result); n_fail++;
      end
    end
    @(posedge clk); #1;
    fe = {2'b00, w == 0, w == 1, 1'b1};
    n_checks++;
    if ({flags, res} !== {fe, exp}) begin
      $display("FAIL done: flags/result got %b/%h expected %b/%h", flags, res, fe, exp); n_fail++;
    end
    exp_result = exp;
    @(posedge clk); #1;
    n_checks++;
    if ({flags, res} !== {5'b00000, exp_result}) begin
      $display("FAIL idle: flags/result got %b/%h expected %b/%h", flags, res, 5'b00000, exp_result); n_fail++;
    end
    txn_no++;
    $display("txn %0d: exec_cyc=%0d m%0d op=%0d a=%h b=%h result=%h", txn_no, ecyc, w, op, a, b, res);
  endtask

  task automatic test_reset();
    sel3 = 1'b0;
    reset_n = 1'b0;
    #2;
    n_checks++;
    if ({flags, res, d3_busy, d3_result} !== {5'b0, 32'h0, 1'b0, 32'h0}) begin
      $display("FAIL reset_state: got %b/%h expected 00000/00000000", flags, res); n_fail++;
    end
    apply_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({flags, res} !== {5'b0, 32'h0}) begin
      $display("FAIL reset_release: got %b/%h expected 00000/00000000", flags, res); n_fail++;
    end
  endtask

  task automatic test_single();
    sel3 = 1'b0;
    apply_reset();
    m0_op = 4'd6; m0_a = 32'hFFFF_FFFF; m0_b = 32'h0000_000F; m0_req = 1'b1;
    run_op(0);
    n_checks++;
    if (res !== 32'h0000_000E) begin $display("FAIL m0_add: got %h expected 0000000e", res); n_fail++; end
    m1_op = 4'd7; m1_a = 32'hF; m1_b = 32'h5; m1_req = 1'b1;
    run_op(0);
    n_checks++;
    if (res !== 32'h0000_000A) begin $display("FAIL m1_sub: got %h expected 0000000a", res); n_fail++; end
    m1_op = 4'd1; m1_a = 32'h3; m1_req = 1'b1;
    run_op(0);
    n_checks++;
    if (res !== 32'hFFFF_FFFC) begin $display("FAIL m1_not: got %h expected fffffffc", res); n_fail++; end
  endtask

  task automatic test_tie();
    sel3 = 1'b0;
    apply_reset();
    m0_op = 4'd2; m0_a = 32'h5; m0_b = 32'h9;
    m1_op = 4'd5; m1_a = 32'h3; m1_b = 32'h5;
    m0_req = 1'b1; m1_req = 1'b1;
    run_op(0);
    n_checks++;
    if (res !== 32'h0000_0001) begin $display("FAIL tie_first: got %h expected 00000001", res); n_fail++; end
    run_op(0);
    n_checks++;
    if (res !== 32'hFFFF_FFF9) begin $display("FAIL tie_second: got %h expected fffffff9", res); n_fail++; end
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (4) run_op(1);
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_illegal_op();
    sel3 = 1'b0;
    apply_reset();
    m0_op = 4'b1010; m0_a = 32'hFFFF_FFFF; m0_b = 32'hFFFF_FFFF; m0_req = 1'b1;
    run_op(0);
    n_checks++;
    if (res !== 32'h0) begin $display("FAIL illegal_op: got %h expected 00000000", res); n_fail++; end
  endtask

  task automatic test_reset_mid_exec();
    sel3 = 1'b1;
    apply_reset();
    m0_op = 4'd3; m0_a = 32'h5; m0_b = 32'hA; m0_req = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (flags !== 5'b10001) begin $display("FAIL abort_gnt: got %b expected 10001", flags); n_fail++; end
    m0_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({flags, res} !== {5'b0, 32'h0}) begin
      $display("FAIL abort_async: got %b/%h expected 00000/00000000", flags, res); n_fail++;
    end
    last_w = 1; exp_result = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({flags, res} !== {5'b0, 32'h0}) begin
        $display("FAIL abort_no_done: got %b/%h expected 00000/00000000", flags, res); n_fail++;
      end
    end
    m0_req = 1'b1;
    run_op(0);
    n_checks++;
    if (res !== 32'h0000_000F) begin $display("FAIL rerequest: got %h expected 0000000f", res); n_fail++; end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      sel3 = (s == 1);
      apply_reset();
      m0_op = 4'd6; m0_a = 32'h1; m0_b = 32'h2; m0_req = 1'b1;
      run_op(1);
      m0_a = 32'hA;
      run_op(0);
      n_checks++;
      if (res !== 32'h0000_000C) begin $display("FAIL back_to_back: got %h expected 0000000c", res); n_fail++; end
    end
  endtask

  task automatic test_random();
    int pat;
    for (int s = 0; s < 2; s++) begin
      sel3 = (s == 1);
      apply_reset();
      for (int i = 0; i < 25; i++) begin
        pat = $urandom_range(1, 3);
        if (pat[0] && !m0_req) begin
          m0_req = 1'b1; m0_op = 4'($urandom_range(0, 15)); m0_a = $urandom; m0_b = $urandom;
        end
        if (pat[1] && !m1_req) begin
          m1_req = 1'b1; m1_op = 4'($urandom_range(0, 15)); m1_a = $urandom; m1_b = $urandom;
        end
        run_op(0);
      end
      while (m0_req || m1_req) run_op(0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_illegal_op();
    test_reset_mid_exec();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_bus_arbiter.md
ALU_BUS_ARBITER -- requirements
Module: alu_bus_arbiter

Interface
REQ-001 Parameter EXEC_CYC, default 1, cycles spent in EXEC before result capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 m0_req, m1_req  input  1 each  master requests one ALU operation.
REQ-005 m0_op, m1_op  input  4 each  ALU opcode: 0 NOP, 1 NOT A, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 ADD, 7 SUB.
REQ-006 m0_a, m0_b, m1_a, m1_b  input  32 each  operands.
REQ-007 m0_gnt, m1_gnt  output  1 each  one-cycle pulse; operands accepted.
REQ-008 m0_done, m1_done  output  1 each  one-cycle pulse; result valid.
REQ-009 result  output  32  registered shared result bus.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Block SHALL instantiate the existing ALU (ports a, b, op, ALU_result) once, driven only from internal operand/op registers.
REQ-012 FSM states SHALL be IDLE, EXEC, DONE; no other states.
REQ-013 req inputs SHALL be sampled only in IDLE; requests during EXEC/DONE wait.
REQ-014 IDLE with any req at an edge -> EXEC; winner's op/a/b latched at that edge; winner's gnt high for the first EXEC cycle only.
REQ-015 Opcodes 8..15 SHALL be latched as 0000 (NOP, result 0x00000000).
REQ-016 EXEC SHALL last exactly EXEC_CYC cycles (internal 4-bit counter); on the last cycle, ALU_result is captured into result and state -> DONE.
REQ-017 DONE SHALL last one cycle; winner's done high in that cycle; then -> IDLE.
REQ-018 Latency with EXEC_CYC=1: req sampled at edge k; gnt during cycle k..k+1; done/result valid during cycle k+1..k+2; IDLE again from edge k+2; throughput one op per EXEC_CYC+2 cycles.
REQ-019 result SHALL hold its last captured value until the next capture.
REQ-020 Masters SHALL deassert req in the gnt cycle; a req still high when state returns to IDLE is a new request.
REQ-021 Only one gnt and one done SHALL be high in any cycle; never to a non-winning master.
REQ-022 Simultaneous m0_req and m1_req: winner chosen per REQ-027/028; loser stays pending and wins the next IDLE arbitration if still requesting.
REQ-023 ADD/SUB SHALL wrap modulo 2^32; no carry/overflow output.

Reset
REQ-024 reset_n low SHALL immediately force IDLE, counter 0, result 0x00000000, all gnt/done 0, busy 0, round-robin pointer such that m0 wins the next tie.
REQ-025 Reset during EXEC or DONE SHALL abort the operation; no done is issued for it and result is not updated.
REQ-026 After reset_n rises, first arbitration occurs at the first clk edge with reset_n high.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: round-robin; on a tie, the master not granted most recently wins; pointer updates on every grant.
REQ-028 ALU_ARB_RR_EN undefined: fixed priority, m0 always wins a tie; no pointer register exists.

Verification
REQ-029 Single m0: op=6, a=0xFFFFFFFF, b=0x0000000F, EXEC_CYC=1 -> m0_gnt 1 cycle after sampling, m0_done next cycle, result=0x0000000E, m1_gnt/m1_done never high.
REQ-030 Single m1: op=7, a=0xF, b=0x5 -> result=0x0000000A on m1_done; then op=1, a=0x3 -> result=0xFFFFFFFC.
REQ-031 Tie, ALU_ARB_RR_EN defined, both req held: m0 AND(0x5,0x9) and m1 XNOR(0x3,0x5) -> m0 served first result=0x00000001, m1 second result=0xFFFFFFF9; grants alternate on repeated ties. Undefined -> m0 wins every tie.
REQ-032 Illegal op 4'b1010 from m0 with a=b=0xFFFFFFFF -> m0_done with result=0x00000000.
REQ-033 EXEC_CYC=3, m0 op=3 a=0x5 b=0xA; reset_n pulsed low in 2nd EXEC cycle -> outputs zero at once, no m0_done, result stays 0; re-request -> result=0x0000000F after 3 EXEC cycles.
REQ-034 Back-to-back: m0 holds req through done -> second gnt in the cycle after returning to IDLE; busy low exactly one cycle between operations.
